// File: rtl/buffer_uart_tx.sv
// Drains bytes from an upstream byte buffer and sends each as an 8N1 UART frame on tx.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits (8E1 framing).
module buffer_uart_tx #(
    parameter int unsigned CLK_PER_BIT      = 16,
    parameter int unsigned BUFFER_ADDR_SIZE = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BUFFER_ADDR_SIZE-1:0] buf_avai,
    input  logic [7:0]                  buf_data,
    output logic                        buf_pop,
    output logic                        tx,
    output logic                        busy
);

    localparam logic [15:0] BitLast = 16'(CLK_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        pop_q, pop_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic avai;
    logic bit_done;

    assign avai     = (buf_avai != '0);
    assign bit_done = (cnt_q == BitLast);

    // pop_q is a registered request: the pop cycle itself is still IDLE, and the byte is
    // captured on the edge that ends it, so the head byte is read before the buffer advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != StIdle) begin
            cnt_d = bit_done ? '0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop_q) begin
                    if (avai) begin
                        shift_d = buf_data;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^buf_data;
`endif
                        cnt_d   = '0;
                        idx_d   = '0;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end
                end else begin
                    pop_d = avai;
                end
            end
            StStart: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                    // Request the next byte now so back-to-back pops land on the first IDLE cycle.
                    pop_d   = avai;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign buf_pop = pop_q & avai & ~reset;
    assign tx      = tx_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Randomized bench for buffer_uart_tx against a frame-level timing model and a line decoder.
module tb_buffer_uart_tx;

    localparam int N  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB       = 11;
    localparam int BUSY_LIT = 44;
    localparam int GAP_LIT  = 45;
`else
    localparam int FB       = 10;
    localparam int BUSY_LIT = 40;
    localparam int GAP_LIT  = 41;
`endif
    localparam int F = FB * N;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] buf_avai = 2'd0;
    logic [7:0] buf_data = 8'h00;
    logic       buf_pop, tx, busy;

    always #5 clk = ~clk;

    buffer_uart_tx #(
        .CLK_PER_BIT      (N),
        .BUFFER_ADDR_SIZE (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .buf_avai (buf_avai),
        .buf_data (buf_data),
        .buf_pop  (buf_pop),
        .tx       (tx),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] q[$];          // upstream buffer contents, head at index 0
    int         pop_cycles[$];
    int         busy_runs[$];
    logic [7:0] rx[$];
    logic       rx_par[$];

    // Model state: frame window and earliest cycle a pop is permitted
    int         ready_at = 1 << 30;
    int         fstart = -100;
    int         fend = -100;
    logic [7:0] fbyte = 8'h00;
    bit         prev_avai = 1'b0;
    bit         pop_seen = 1'b0;
    int         brun = 0;
    int         dec_cnt = -1;
    logic [7:0] dec_byte = 8'h00;
    logic       dec_par = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        bit cur_avai, e_pop, e_busy, e_tx;
        int k;
        cur_avai = (q.size() != 0);
        if (cyc >= 1) begin
            e_pop = !reset && cur_avai && prev_avai && (cyc >= ready_at);
            if (cyc > fstart && cyc <= fend) begin
                e_busy = 1'b1;
                e_tx   = frame_bit(fbyte, (cyc - fstart - 1) / N);
            end else begin
                e_busy = 1'b0;
                e_tx   = 1'b1;
            end
            check("buf_pop", buf_pop, e_pop);
            check("tx", tx, e_tx);
            check("busy", busy, e_busy);
            if (e_pop) begin
                fstart   = cyc;
                fend     = cyc + F;
                fbyte    = q[0];
                ready_at = cyc + F + 1;
            end
            if (reset) begin
                if (fend > cyc) fend = cyc;
                ready_at = cyc + 2;
            end
        end
        pop_seen  = (buf_pop === 1'b1);
        prev_avai = cur_avai;
        if (buf_pop === 1'b1) pop_cycles.push_back(cyc);
        if (busy === 1'b1) brun++;
        else if (brun > 0) begin
            busy_runs.push_back(brun);
            brun = 0;
        end
        // Line decoder: samples mid-bit after each falling start edge
        if (reset) dec_cnt = -1;
        else if (dec_cnt >= 0) dec_cnt++;
        else if (tx === 1'b0) dec_cnt = 0;
        if (dec_cnt >= 0 && (dec_cnt % N) == N / 2) begin
            k = dec_cnt / N;
            if (k >= 1 && k <= 8) dec_byte[k-1] = tx;
            if (FB == 11 && k == 9) dec_par = tx;
            if (k == FB - 1) begin
                check("stop_bit", tx, 1'b1);
                rx.push_back(dec_byte);
                rx_par.push_back(dec_par);
                dec_cnt = -1;
            end
        end
    end

    task automatic drive_buf();
        buf_avai = (q.size() > 3) ? 2'd3 : 2'(q.size());
        buf_data = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen) begin
            void'(q.pop_front());
            pop_seen = 1'b0;
        end
        drive_buf();
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        drive_buf();
    endtask

    task automatic wait_pop(input int n0);
        int t = 0;
        while (pop_cycles.size() <= n0 && t < 300) begin
            tick();
            t++;
        end
        check("pop_timeout", 32'(pop_cycles.size() > n0), 1);
    endtask

    initial begin
        int c0, p, nrx, npop;
        drive_buf();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pop", buf_pop, 1'b0);
        reset = 1'b0;

        // Empty buffer: line stays idle
        repeat (100) tick();
        check("idle_pops", pop_cycles.size(), 0);
        check("idle_busy_runs", busy_runs.size(), 0);

        // Single byte 0x55
        c0 = cyc;
        push(8'h55);
        wait_pop(0);
        repeat (F + 10) tick();
        check("pop_latency", pop_cycles[0] - c0, 1);
        check("single_pops", pop_cycles.size(), 1);
        check("single_busy_len", busy_runs[0], BUSY_LIT);
        check("single_rx", rx[0], 8'h55);

        // Three queued bytes back to back
        push(8'hA5);
        push(8'h00);
        push(8'hFF);
        repeat (3 * (F + 1) + 20) tick();
        check("gap1", pop_cycles[2] - pop_cycles[1], GAP_LIT);
        check("gap2", pop_cycles[3] - pop_cycles[2], GAP_LIT);
        check("rx_a5", rx[1], 8'hA5);
        check("rx_00", rx[2], 8'h00);
        check("rx_ff", rx[3], 8'hFF);
        check("trio_busy_len", busy_runs[2], BUSY_LIT);

        // Upstream data changing while a frame is in flight
        push(8'h11);
        repeat (10) tick();
        push(8'h22);
        repeat (5) tick();
        q[0] = 8'h33;
        drive_buf();
        repeat (2 * F + 20) tick();
        check("inflight_rx0", rx[4], 8'h11);
        check("inflight_rx1", rx[5], 8'h33);

        // Reset during data bit 3 of 0x3C
        npop = pop_cycles.size();
        nrx = rx.size();
        push(8'h3C);
        push(8'h81);
        wait_pop(npop);
        p = pop_cycles[npop];
        while (cyc < p + 18) tick();
        reset = 1'b1;
        tick();
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        tick();
        check("abort_nopop", buf_pop, 1'b0);
        tick();
        reset = 1'b0;
        repeat (F + 30) tick();
        check("abort_pops", pop_cycles.size(), npop + 2);
        check("abort_repop_delay", 32'(pop_cycles[npop+1] - p >= 22), 1);
        check("abort_rx_count", rx.size(), nrx + 1);
        check("abort_rx", rx[nrx], 8'h81);

`ifdef UART_TX_PARITY_EN
        nrx = rx.size();
        npop = busy_runs.size();
        push(8'h07);
        push(8'h03);
        repeat (2 * (F + 1) + 20) tick();
        check("par07_bit", rx_par[nrx], 1'b1);
        check("par03_bit", rx_par[nrx+1], 1'b0);
        check("par_busy_len", busy_runs[npop], 44);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0 && q.size() < 5) push(8'($urandom));
            if ($urandom_range(0, 699) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 8 * (F + 1) && q.size() != 0; i++) tick();
        repeat (F + 5) tick();
        check("drained", q.size(), 0);
        check("final_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_uart_tx.md
BUFFER_UART_TX -- requirements
Module: buffer_uart_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter BUFFER_ADDR_SIZE, default 2: width of buf_avai, matching the byte buffer's occupancy count width.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port buf_avai  input  BUFFER_ADDR_SIZE  occupancy of the upstream byte buffer; nonzero means the head byte is valid.
REQ-006 SHALL have port buf_data  input  8  head byte of the upstream buffer, valid combinationally whenever buf_avai != 0.
REQ-007 SHALL have port buf_pop  output  1  one-cycle pulse that consumes the head byte (drives the buffer's output_en).
REQ-008 SHALL have port tx  output  1  serial line output, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only when enabled) and STOP.
REQ-011 In IDLE with buf_avai != 0: SHALL assert buf_pop for exactly one cycle, capture buf_data into the shift register in the same cycle, and enter START on the next cycle.
REQ-012 In IDLE with buf_avai == 0: SHALL hold buf_pop=0 and tx=1.
REQ-013 buf_pop SHALL never be asserted outside IDLE, and SHALL never be asserted while buf_avai == 0.
REQ-014 The tx falling edge (start bit) SHALL appear on the cycle after buf_pop; latency pop->start = 1 cycle.
REQ-015 Each bit (start, data, parity, stop) SHALL hold tx for exactly CLK_PER_BIT cycles, timed by a bit-timer counter that restarts at every state or bit change.
REQ-016 START SHALL drive tx=0.
REQ-017 DATA SHALL send 8 bits LSB first; an internal bit index counts 0..7, and after bit 7 the FSM moves to PARITY if enabled, otherwise to STOP.
REQ-018 STOP SHALL drive tx=1 for CLK_PER_BIT cycles, then return to IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLK_PER_BIT cycles (11*CLK_PER_BIT with parity).
REQ-020 Back-to-back bytes: the next buf_pop SHALL occur on the first IDLE cycle after STOP; the pop-to-pop period SHALL be frame length + 1 cycle.
REQ-021 Changes to buf_data or buf_avai during a frame SHALL NOT affect the frame in flight.
REQ-022 tx SHALL be driven from a register (glitch-free).

Reset
REQ-023 On reset: state=IDLE, tx=1, buf_pop=0, busy=0, bit timer=0, bit index=0, shift register=0x00.
REQ-024 A reset asserted mid-frame SHALL abort the frame: tx=1 on the cycle after reset is sampled, the byte is not retransmitted, and no buf_pop is issued while reset is high.
REQ-025 The first pop after reset deasserts SHALL occur no earlier than the cycle after the first non-reset clock edge with buf_avai != 0.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, SHALL insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles; frame length becomes 11 bits.
REQ-027 Without UART_TX_PARITY_EN: the PARITY state and its logic SHALL be absent, and the frame is 8N1 (10 bits).

Verification (CLK_PER_BIT=4, no parity unless stated)
REQ-028 One byte 0x55 present (buf_avai=1) -> buf_pop high for exactly 1 cycle, then tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; busy high for 40 cycles.
REQ-029 Three bytes 0xA5, 0x00, 0xFF queued -> pops exactly 41 cycles apart; line decodes to A5, 00, FF; tx high between frames.
REQ-030 buf_avai=0 for 100 cycles -> no buf_pop, tx=1, busy=0 throughout.
REQ-031 Reset asserted during data bit 3 of 0x3C -> tx=1 and busy=0 the cycle after; no pop while reset is high; the next queued byte transmits normally after reset deasserts.
REQ-032 With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 and frame length 44 cycles; byte 0x03 -> parity bit 0.
REQ-033 buf_data changed mid-frame -> transmitted byte equals the value captured at buf_pop.
